lsu_dmem_ctrl: RTL and testbench
================================

# lsu_dmem_ctrl

Load/store unit front end that drives the `data_memo` data memory from the core's execute stage. It accepts one load or store request at a time over a valid/ready handshake and computes the effective address. It checks the address and `funct3` and issues a single-cycle `ren`/`wen` strobe to the memory. It returns the load value or store completion, or an error code, over a valid/ready response channel.

## Interface
- `ADDR_WIDTH`, 8, memory address width; matches `data_memo` `ADDR_WIDTH`.
- `clk` in 1: the only clock; all logic updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept a request.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V width/sign code.
- `req_base` in 32: rs1 value.
- `req_offset` in 12: signed immediate.
- `req_wdata` in 32: store data (rs2).
- `req_rd` in 5: load destination register.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: core accepts response.
- `resp_rd` out 5: echoed `req_rd`.
- `resp_data` out 32: load result; 0 for stores and errors.
- `resp_addr` out 32: effective address.
- `resp_err` out 2: 0 = ok, 1 = misaligned, 2 = out of range, 3 = illegal `funct3`.
- `mem_ren` out 1: to `data_memo.ren`.
- `mem_wen` out 1: to `data_memo.wen`.
- `mem_funct3` out 3: to `data_memo.funct3`.
- `mem_addr` out ADDR_WIDTH: to `data_memo.addr`.
- `mem_wdata` out 32: to `data_memo.wdata`.
- `mem_rdata` in 32: from `data_memo.rdata`; already width/sign-adjusted by memory; valid the cycle after the `mem_ren` cycle.

## Operation
- **FSM states:** IDLE, ACCESS, WAIT, RESP.
- **Acceptance:** `req_ready` = (state == IDLE). A request is accepted on an edge where `req_valid && req_ready`. On acceptance all request fields are registered.
- **Effective address:** `eff = req_base + sign_extend(req_offset)`, modulo 2^32.
- **Checks,** evaluated at acceptance, first match wins:
  - `funct3` illegal → err 3. Legal loads are {000,001,010,100,101}; legal stores are {000,001,010}.
  - Misaligned → err 1. Halfword (`x01`) requires `eff[0]`=0; word (`010`) requires `eff[1:0]`=0.
  - Out of range → err 2, when `eff[31:ADDR_WIDTH]` ≠ 0.
- **Error path:** IDLE → RESP directly. No `mem_ren`/`mem_wen` is ever asserted.
- **OK path:** IDLE → ACCESS.
  - In ACCESS, the LSU drives exactly one cycle of `mem_wen` (store) or `mem_ren` (load), with `mem_addr` = `eff[ADDR_WIDTH-1:0]`, `mem_funct3`, and `mem_wdata` = `req_wdata` unmodified (memory selects the bytes).
  - Store: ACCESS → RESP.
  - Load: ACCESS → WAIT. At the end of WAIT, `mem_rdata` is captured into `resp_data`, then WAIT → RESP.
- **RESP:** `resp_valid`=1. All `resp_*` outputs are stable while `resp_ready`=0. The edge with `resp_ready`=1 returns the FSM to IDLE.
- **Memory outputs outside ACCESS:** `mem_ren`=`mem_wen`=0. `mem_addr`, `mem_funct3` and `mem_wdata` hold their last value.

## Timing
- **Reset values:** `req_ready`=0 during reset cycles and 1 from the first cycle after `rst` deasserts. All other outputs are 0; state = IDLE.
- **Latency,** counted from the accept edge to the first cycle with `resp_valid`:
  - Store: 2 cycles.
  - Load: 3 cycles.
  - Error: 1 cycle.
- **Throughput:** minimum back-to-back spacing is 3 cycles per store and 4 per load. `req_ready` returns 1 the cycle after the response handshake.
- **Strobe width:** `mem_ren`/`mem_wen` are high for exactly one cycle per accepted OK request and never both at once.
- **Reset mid-operation:** `rst` in any state forces IDLE and zeroes all outputs on that edge.
  - A store strobe already sampled by memory stays committed.
  - A load in WAIT is dropped with no response.
- **Back-pressure:** `resp_ready` held low keeps the FSM in RESP indefinitely. `req_valid` is ignored during that time.

## Test plan
- **SB / LB:**
  - Store: base 0x10, off 0, `funct3` 000, wdata 0x000000AA. Expect `mem_wen` for one cycle at addr 0x10, then `resp_err`=0 two cycles after accept.
  - Load: same address, `funct3` 000. Expect `resp_data` = memory's LB value, 3 cycles after accept.
- **SH / LH / LHU:**
  - Store 0x0000BEEF to 0x20.
  - LH (001) → `resp_data` 0xFFFFBEEF.
  - LHU (101) → `resp_data` 0x0000BEEF.
  - `resp_rd` echoes `req_rd` in both cases.
- **Negative offset:** SW with base 0x34, off 0xFFC (−4), wdata 0xDEADBEEF → `mem_addr` 0x30. Then LW at 0x30 → 0xDEADBEEF.
- **Errors:** each case must show no memory strobe, `resp_valid` 1 cycle after accept, and `resp_data`=0.
  - LW at 0x31 → err 1, `resp_addr` 0x31.
  - LB at 0x100 → err 2.
  - Store with `funct3` 100 → err 3.
- **Back-pressure:** load response held with `resp_ready`=0 for 5 cycles → `resp_*` stable and `req_ready`=0. After the handshake, `req_ready`=1 the next cycle.
- **Reset in WAIT:** `rst` asserted during WAIT → next cycle state IDLE, `resp_valid`=0, `mem_ren`=0. `req_ready`=1 one cycle after `rst` deasserts.

Source files
------------

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit front end for the data_memo data memory.
// Accepts one request at a time, computes the effective address, screens
// funct3, alignment and range, then issues a single-cycle ren/wen strobe
// and returns the result or an error code over a valid/ready channel.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_base,
  input  logic [11:0]           req_offset,
  input  logic [31:0]           req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [4:0]            resp_rd,
  output logic [31:0]           resp_data,
  output logic [31:0]           resp_addr,
  output logic [1:0]            resp_err,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  localparam logic [1:0] ErrOk       = 2'd0;
  localparam logic [1:0] ErrMisalign = 2'd1;
  localparam logic [1:0] ErrRange    = 2'd2;
  localparam logic [1:0] ErrFunct3   = 2'd3;

  state_e      state;
  logic        is_store_q;

  logic [31:0] eff;
  logic        legal;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  chk_err;

  // Effective address and request screening, first failing check wins.
  always_comb begin
    eff = req_base + {{20{req_offset[11]}}, req_offset};

    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~req_is_store;
      default:                legal = 1'b0;
    endcase

    misaligned = 1'b0;
    if (req_funct3[1:0] == 2'b01) begin
      misaligned = eff[0];
    end else if (req_funct3[1:0] == 2'b10) begin
      misaligned = |eff[1:0];
    end

    out_of_range = |(eff >> ADDR_WIDTH);

    if (!legal) begin
      chk_err = ErrFunct3;
    end else if (misaligned) begin
      chk_err = ErrMisalign;
    end else if (out_of_range) begin
      chk_err = ErrRange;
    end else begin
      chk_err = ErrOk;
    end
  end

  // Control FSM with all outputs registered; req_ready is held low through
  // reset and rises on the first non-reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      is_store_q <= 1'b0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rd    <= '0;
      resp_data  <= '0;
      resp_addr  <= '0;
      resp_err   <= '0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_funct3 <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // Strobes last exactly one cycle: only set on the accept edge.
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      case (state)
        StIdle: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready  <= 1'b0;
            is_store_q <= req_is_store;
            resp_rd    <= req_rd;
            resp_addr  <= eff;
            resp_err   <= chk_err;
            resp_data  <= '0;
            if (chk_err != ErrOk) begin
              state      <= StResp;
              resp_valid <= 1'b1;
            end else begin
              state      <= StAccess;
              mem_ren    <= ~req_is_store;
              mem_wen    <= req_is_store;
              mem_addr   <= eff[ADDR_WIDTH-1:0];
              mem_funct3 <= req_funct3;
              mem_wdata  <= req_wdata;
            end
          end
        end
        StAccess: begin
          if (is_store_q) begin
            state      <= StResp;
            resp_valid <= 1'b1;
          end else begin
            state <= StWait;
          end
        end
        StWait: begin
          // Memory returns read data the cycle after the ren cycle.
          resp_data  <= mem_rdata;
          resp_valid <= 1'b1;
          state      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Self-checking bench for lsu_dmem_ctrl: directed scenarios plus random
// traffic compared against a byte-array reference model of data memory.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_base = '0;
  logic [11:0] req_offset = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic [31:0] resp_addr;
  logic [1:0]  resp_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [2:0]  mem_funct3;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int both_cnt = 0;
  logic [7:0] strobe_addr = '0;

  logic [7:0] mem     [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  lsu_dmem_ctrl #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_addr(resp_addr), .resp_err(resp_err),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // data_memo stand-in: byte-lane writes, registered width/sign-adjusted reads.
  always @(posedge clk) begin
    if (mem_wen) begin
      case (mem_funct3[1:0])
        2'b00: mem[mem_addr] <= mem_wdata[7:0];
        2'b01: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[8'(mem_addr + 1)] <= mem_wdata[15:8];
        end
        default: begin
          for (int k = 0; k < 4; k++) mem[8'(mem_addr + k)] <= mem_wdata[8*k +: 8];
        end
      endcase
    end
    if (mem_ren) begin
      case (mem_funct3)
        3'b000:  mem_rdata <= {{24{mem[mem_addr][7]}}, mem[mem_addr]};
        3'b001:  mem_rdata <= {{16{mem[8'(mem_addr + 1)][7]}}, mem[8'(mem_addr + 1)],
                               mem[mem_addr]};
        3'b100:  mem_rdata <= {24'h0, mem[mem_addr]};
        3'b101:  mem_rdata <= {16'h0, mem[8'(mem_addr + 1)], mem[mem_addr]};
        default: mem_rdata <= {mem[8'(mem_addr + 3)], mem[8'(mem_addr + 2)],
                               mem[8'(mem_addr + 1)], mem[mem_addr]};
      endcase
    end
  end

  // Strobe monitor.
  always @(posedge clk) begin
    if (mem_wen) begin
      wen_cnt++;
      strobe_addr = mem_addr;
    end
    if (mem_ren) begin
      ren_cnt++;
      strobe_addr = mem_addr;
    end
    if (mem_wen && mem_ren) both_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [1:0] ref_err(bit st, logic [2:0] f3, logic [31:0] eff);
    bit legal;
    int unsigned size;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    if (!legal) return 2'd3;
    if (eff % size != 0) return 2'd1;
    if (eff >= 32'd256) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] ref_load(logic [2:0] f3, logic [31:0] a);
    int unsigned size;
    logic [31:0] v;
    size = 1 << f3[1:0];
    v = '0;
    for (int k = 0; k < size; k++) v = v | (32'(ref_mem[8'(a + k)]) << (8 * k));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
    return v;
  endfunction

  task automatic ref_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    int unsigned size;
    size = 1 << f3[1:0];
    for (int k = 0; k < size; k++) ref_mem[8'(a + k)] = d[8*k +: 8];
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for its response; lat = -1 on timeout.
  task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] base,
                       input logic [11:0] off, input logic [31:0] wd, input logic [4:0] rd,
                       output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) begin
      lat = -1;
      return;
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_base = base;
    req_offset = off; req_wdata = wd; req_rd = rd;
    wen_cnt = 0; ren_cnt = 0; both_cnt = 0;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!resp_valid) lat = -1;
  endtask

  task automatic complete();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_cmp++; if ({resp_valid, mem_ren, mem_wen} !== 3'b000) begin n_bad++; $display("FAIL rst_strobes: got %b want 000", {resp_valid, mem_ren, mem_wen}); end
    n_cmp++; if ({resp_data, resp_addr, resp_err, resp_rd} !== 71'd0) begin n_bad++; $display("FAIL rst_resp: got data %h addr %h err %0d rd %0d want all 0", resp_data, resp_addr, resp_err, resp_rd); end
    n_cmp++; if ({mem_addr, mem_funct3, mem_wdata} !== 43'd0) begin n_bad++; $display("FAIL rst_mem: got addr %h f3 %0d wdata %h want 0", mem_addr, mem_funct3, mem_wdata); end
    rst = 1'b0;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_byte();
    int lat;
    issue(1'b1, 3'b000, 32'h10, 12'h000, 32'h000000AA, 5'd3, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sb_latency: got %0d want 2", lat); end
    n_cmp++; if (resp_err !== 2'd0 || resp_data !== 32'd0) begin n_bad++; $display("FAIL sb_resp: got err %0d data %h want 0 0", resp_err, resp_data); end
    n_cmp++; if (wen_cnt !== 1 || ren_cnt !== 0 || strobe_addr !== 8'h10) begin n_bad++; $display("FAIL sb_strobe: got wen %0d ren %0d addr %h want 1 0 10", wen_cnt, ren_cnt, strobe_addr); end
    complete();
    ref_store(3'b000, 32'h10, 32'h000000AA);
    issue(1'b0, 3'b000, 32'h10, 12'h000, 32'h0, 5'd4, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL lb_latency: got %0d want 3", lat); end
    n_cmp++; if (resp_data !== 32'hFFFFFFAA) begin n_bad++; $display("FAIL lb_data: got %h want FFFFFFAA", resp_data); end
    n_cmp++; if (ren_cnt !== 1 || wen_cnt !== 0) begin n_bad++; $display("FAIL lb_strobe: got ren %0d wen %0d want 1 0", ren_cnt, wen_cnt); end
    complete();
  endtask

  task automatic test_half();
    int lat;
    issue(1'b1, 3'b001, 32'h20, 12'h000, 32'h0000BEEF, 5'd1, lat);
    complete();
    ref_store(3'b001, 32'h20, 32'h0000BEEF);
    issue(1'b0, 3'b001, 32'h20, 12'h000, 32'h0, 5'd7, lat);
    n_cmp++; if (resp_data !== 32'hFFFFBEEF || resp_rd !== 5'd7) begin n_bad++; $display("FAIL lh: got data %h rd %0d want FFFFBEEF 7", resp_data, resp_rd); end
    complete();
    issue(1'b0, 3'b101, 32'h20, 12'h000, 32'h0, 5'd9, lat);
    n_cmp++; if (resp_data !== 32'h0000BEEF || resp_rd !== 5'd9) begin n_bad++; $display("FAIL lhu: got data %h rd %0d want 0000BEEF 9", resp_data, resp_rd); end
    complete();
  endtask

  task automatic test_neg_offset();
    int lat;
    issue(1'b1, 3'b010, 32'h34, 12'hFFC, 32'hDEADBEEF, 5'd2, lat);
    n_cmp++; if (strobe_addr !== 8'h30 || resp_addr !== 32'h30) begin n_bad++; $display("FAIL sw_negoff_addr: got mem %h resp %h want 30", strobe_addr, resp_addr); end
    complete();
    ref_store(3'b010, 32'h30, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h30, 12'h000, 32'h0, 5'd5, lat);
    n_cmp++; if (resp_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_negoff: got %h want DEADBEEF", resp_data); end
    complete();
  endtask

  task automatic test_errors();
    int lat;
    issue(1'b0, 3'b010, 32'h31, 12'h000, 32'h0, 5'd6, lat);
    n_cmp++; if (lat !== 1 || resp_err !== 2'd1 || resp_addr !== 32'h31) begin n_bad++; $display("FAIL err_misalign: got lat %0d err %0d addr %h want 1 1 31", lat, resp_err, resp_addr); end
    n_cmp++; if (wen_cnt + ren_cnt !== 0 || resp_data !== 32'd0) begin n_bad++; $display("FAIL err_misalign_side: got strobes %0d data %h want 0 0", wen_cnt + ren_cnt, resp_data); end
    complete();
    issue(1'b0, 3'b000, 32'h100, 12'h000, 32'h0, 5'd6, lat);
    n_cmp++; if (lat !== 1 || resp_err !== 2'd2 || wen_cnt + ren_cnt !== 0) begin n_bad++; $display("FAIL err_range: got lat %0d err %0d strobes %0d want 1 2 0", lat, resp_err, wen_cnt + ren_cnt); end
    complete();
    issue(1'b1, 3'b100, 32'h40, 12'h000, 32'h12345678, 5'd6, lat);
    n_cmp++; if (lat !== 1 || resp_err !== 2'd3 || wen_cnt + ren_cnt !== 0 || resp_data !== 32'd0) begin n_bad++; $display("FAIL err_funct3: got lat %0d err %0d strobes %0d data %h want 1 3 0 0", lat, resp_err, wen_cnt + ren_cnt, resp_data); end
    complete();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1'b0, 3'b010, 32'h30, 12'h000, 32'h0, 5'd11, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_latency: got %0d want 3", lat); end
    // A competing request must be ignored while the response is pending.
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b010; req_base = 32'h80;
    req_wdata = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_addr !== 32'h30 ||
          resp_err !== 2'd0 || resp_rd !== 5'd11 || req_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: got v %b data %h addr %h err %0d rd %0d rdy %b want 1 DEADBEEF 30 0 11 0",
                 i, resp_valid, resp_data, resp_addr, resp_err, resp_rd, req_ready);
      end
    end
    req_valid = 1'b0;
    n_cmp++; if (wen_cnt !== 0) begin n_bad++; $display("FAIL bp_no_store: got wen %0d want 0", wen_cnt); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got rdy %b v %b want 1 0", req_ready, resp_valid); end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    for (int pass = 0; pass < 2; pass++) begin
      acc.delete();
      wen_cnt = 0; ren_cnt = 0; both_cnt = 0;
      resp_ready = 1'b1;
      req_valid = 1'b1; req_is_store = (pass == 0); req_funct3 = 3'b000;
      req_base = 32'h40; req_offset = '0; req_wdata = 32'h0000005A; req_rd = 5'd8;
      for (int c = 0; c < 12; c++) begin
        if (req_valid && req_ready) acc.push_back(c);
        step();
      end
      req_valid = 1'b0;
      step();
      step();
      resp_ready = 1'b0;
      if (pass == 0) ref_store(3'b000, 32'h40, 32'h5A);
      n_cmp++;
      if (acc.size() < 3 || acc[1] - acc[0] !== (pass == 0 ? 3 : 4) ||
          acc[2] - acc[1] !== (pass == 0 ? 3 : 4)) begin
        n_bad++;
        $display("FAIL b2b_spacing_%s: got %0d accepts, first gaps %0d %0d want %0d",
                 pass == 0 ? "store" : "load", acc.size(),
                 acc.size() > 1 ? acc[1] - acc[0] : -1, acc.size() > 2 ? acc[2] - acc[1] : -1,
                 pass == 0 ? 3 : 4);
      end
      n_cmp++;
      if ((pass == 0 ? wen_cnt : ren_cnt) !== acc.size() || both_cnt !== 0) begin
        n_bad++;
        $display("FAIL b2b_strobes: got %0d strobes (both %0d) want %0d", pass == 0 ? wen_cnt : ren_cnt, both_cnt, acc.size());
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int seen;
    while (!req_ready) step();
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h30;
    req_offset = '0; req_rd = 5'd12;
    step();
    req_valid = 1'b0;
    n_cmp++; if (mem_ren !== 1'b1) begin n_bad++; $display("FAIL rw_access_ren: got %b want 1", mem_ren); end
    step();
    rst = 1'b1;
    step();
    n_cmp++; if ({resp_valid, mem_ren, req_ready} !== 3'b000 || resp_data !== 32'd0) begin n_bad++; $display("FAIL rw_reset: got v %b ren %b rdy %b data %h want 0 0 0 0", resp_valid, mem_ren, req_ready, resp_data); end
    rst = 1'b0;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rw_ready: got %b want 1", req_ready); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL rw_dropped: got %0d resp cycles want 0", seen); end
  endtask

  task automatic test_random();
    bit          st;
    logic [2:0]  f3;
    logic [31:0] base, wd, eff, exp_data;
    logic [11:0] off;
    logic [4:0]  rd;
    logic [1:0]  e;
    int          soff, lat, exp_lat;
    for (int it = 0; it < 60; it++) begin
      st   = 1'($urandom);
      f3   = ($urandom % 4 == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
      if (!st && $urandom % 3 == 0) f3 = {1'b1, 2'($urandom_range(0, 1))};
      base = 32'($urandom_range(0, 300));
      off  = ($urandom % 5 == 0) ? 12'($urandom) : 12'($urandom_range(0, 12));
      wd   = $urandom;
      rd   = 5'($urandom);
      soff = off[11] ? int'(off) - 4096 : int'(off);
      eff  = base + 32'(soff);
      e    = ref_err(st, f3, eff);
      exp_data = (e == 2'd0 && !st) ? ref_load(f3, eff) : 32'd0;
      exp_lat  = (e != 2'd0) ? 1 : (st ? 2 : 3);
      issue(st, f3, base, off, wd, rd, lat);
      n_cmp++;
      if (lat !== exp_lat || resp_err !== e || resp_addr !== eff || resp_rd !== rd ||
          resp_data !== exp_data) begin
        n_bad++;
        $display("FAIL rand[%0d] st%0d f3=%0d: got lat %0d err %0d addr %h rd %0d data %h want %0d %0d %h %0d %h",
                 it, st, f3, lat, resp_err, resp_addr, resp_rd, resp_data, exp_lat, e, eff, rd, exp_data);
      end
      n_cmp++;
      if (wen_cnt !== ((e == 2'd0 && st) ? 1 : 0) || ren_cnt !== ((e == 2'd0 && !st) ? 1 : 0) ||
          both_cnt !== 0) begin
        n_bad++;
        $display("FAIL rand_strobe[%0d]: got wen %0d ren %0d both %0d", it, wen_cnt, ren_cnt, both_cnt);
      end
      complete();
      if (e == 2'd0 && st) ref_store(f3, eff, wd);
    end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_neg_offset();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
